// File: rtl/simon_playback_sequencer.sv
// Timed Simon pattern playback: shows each stored pattern for ON_CYCLES, blanks for OFF_CYCLES,
// walks addresses 0..count_q-1 and pulses done once at the end.
module simon_playback_sequencer #(
    parameter int ADDR_W     = 5,
    parameter int PAT_W      = 4,
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2,
    parameter int TIMER_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   count,
    input  logic [PAT_W-1:0]  mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [PAT_W-1:0]  leds,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start, index held at 0
    // SHOW  | current entry driven onto leds for ON_CYCLES
    // GAP   | leds blanked for OFF_CYCLES between entries
    // DONE  | one-cycle completion pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [ADDR_W:0]    DEPTH    = {1'b1, {ADDR_W{1'b0}}};

    state_t              state, state_n;
    logic [ADDR_W-1:0]   index, index_n;
    logic [ADDR_W:0]     count_q, count_q_n;
    logic [TIMER_W-1:0]  timer, timer_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            index   <= '0;
            count_q <= '0;
            timer   <= '0;
        end else begin
            state   <= state_n;
            index   <= index_n;
            count_q <= count_q_n;
            timer   <= timer_n;
        end
    end

    always_comb begin
        state_n   = state;
        index_n   = index;
        count_q_n = count_q;
        timer_n   = timer;
        if (abort) begin
            state_n = IDLE;
            index_n = '0;
            timer_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    index_n = '0;
                    timer_n = '0;
                    if (start) begin
                        if (count == '0) begin
                            state_n = DONE;
                        end else begin
                            // clamp so index can never run past the last memory word
                            count_q_n = (count > DEPTH) ? DEPTH : count;
                            state_n   = SHOW;
                        end
                    end
                end
                SHOW: begin
                    if (timer == ON_LAST) begin
                        timer_n = '0;
                        state_n = GAP;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                GAP: begin
                    if (timer == OFF_LAST) begin
                        timer_n = '0;
                        if ({1'b0, index} == count_q - 1'b1) begin
                            state_n = DONE;
                        end else begin
                            index_n = index + 1'b1;
                            state_n = SHOW;
                        end
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                DONE: begin
                    index_n = '0;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign mem_addr = index;
    assign leds     = (state == SHOW) ? mem_data : '0;
    assign busy     = (state == SHOW) || (state == GAP);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Scoreboard bench for simon_playback_sequencer: stimulus queues the expected per-cycle outputs,
// a negedge monitor pops one entry per cycle (idle-zero when the queue is empty) and compares.
module tb_simon_playback_sequencer;

    logic       clk, rst, start, abort;
    logic [5:0] count;
    logic [3:0] mem_data, leds;
    logic [4:0] mem_addr;
    logic       busy, done;
    logic [3:0] mem [32];

    int checks = 0;
    int passes = 0;
    bit mon_en = 0;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] leds;
        logic [4:0] addr;
        logic       chk_addr;
    } exp_t;

    exp_t q[$];

    simon_playback_sequencer #(
        .ADDR_W(5), .PAT_W(4), .ON_CYCLES(4), .OFF_CYCLES(2), .TIMER_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .count(count),
        .mem_data(mem_data), .mem_addr(mem_addr), .leds(leds), .busy(busy), .done(done)
    );

    assign mem_data = mem[mem_addr];

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic b, logic d, logic [3:0] l, logic [4:0] a, logic c);
        exp_t e;
        e.busy = b; e.done = d; e.leds = l; e.addr = a; e.chk_addr = c;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        if (mon_en) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = mk(1'b0, 1'b0, 4'h0, 5'd0, 1'b1);
            ok = (busy === e.busy) && (done === e.done) && (leds === e.leds) &&
                 (!e.chk_addr || (mem_addr === e.addr));
            checks++;
            if (ok) passes++;
            else $display("FAIL outputs @%0t: got busy=%b done=%b leds=%h addr=%0d, want busy=%b done=%b leds=%h addr=%0d(chk=%b)",
                          $time, busy, done, leds, mem_addr, e.busy, e.done, e.leds, e.addr, e.chk_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_show(input int k);
        for (int c = 0; c < 4; c++) q.push_back(mk(1'b1, 1'b0, mem[k], 5'(k), 1'b1));
    endtask

    task automatic push_gap(input int k);
        for (int c = 0; c < 2; c++) q.push_back(mk(1'b1, 1'b0, 4'h0, 5'(k), 1'b1));
    endtask

    // Expected outputs from the cycle in which start is driven through the done pulse.
    task automatic push_play(input int n);
        q.push_back(mk(1'b0, 1'b0, 4'h0, 5'd0, 1'b1));
        for (int k = 0; k < n; k++) begin
            push_show(k);
            push_gap(k);
        end
        q.push_back(mk(1'b0, 1'b1, 4'h0, 5'd0, n == 0));
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain_%s: %0d expected cycles left, want 0", name, q.size());
            q.delete();
        end
        repeat (2) tick();
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; count = 0;
        for (int i = 0; i < 32; i++) mem[i] = 4'h0;
        mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4;

        // reset values: 2 reset cycles then 5 idle cycles, all outputs zero
        tick();
        mon_en = 1;
        tick();
        rst = 0;
        repeat (5) tick();

        // normal playback of three entries
        count = 6'd3;
        push_play(3);
        pulse_start();
        drain("normal");

        // empty pattern: done next cycle, nothing shown
        count = 6'd0;
        push_play(0);
        pulse_start();
        drain("empty");

        // abort during the second entry's SHOW, then replay from address 0
        count = 6'd3;
        q.push_back(mk(1'b0, 1'b0, 4'h0, 5'd0, 1'b1));
        push_show(0);
        push_gap(0);
        q.push_back(mk(1'b1, 1'b0, 4'h2, 5'd1, 1'b1));
        q.push_back(mk(1'b1, 1'b0, 4'h2, 5'd1, 1'b1));
        pulse_start();
        repeat (7) tick();
        abort = 1;
        tick();
        abort = 0;
        drain("abort");
        push_play(3);
        pulse_start();
        drain("replay");

        // start and count changes while busy are ignored
        count = 6'd3;
        push_play(3);
        pulse_start();
        count = 6'd7;
        repeat (5) tick();
        start = 1;
        tick();
        start = 0;
        drain("ignored");

        // full memory, addresses 0..31 with no wrap
        for (int i = 0; i < 32; i++) mem[i] = 4'((i * 7 + 1) & 15);
        count = 6'd32;
        push_play(32);
        pulse_start();
        drain("full");

        // oversized count clamps to the memory depth
        count = 6'd63;
        push_play(32);
        pulse_start();
        drain("clamp");

        // synchronous reset during the first GAP cycle
        count = 6'd3;
        q.push_back(mk(1'b0, 1'b0, 4'h0, 5'd0, 1'b1));
        push_show(0);
        q.push_back(mk(1'b1, 1'b0, 4'h0, 5'd0, 1'b1));
        pulse_start();
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        drain("rst_gap");

        // recovery after reset
        count = 6'd2;
        push_play(2);
        pulse_start();
        drain("recover");

        repeat (3) tick();
        mon_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
